// File: rtl/fsm_harness_pkg.sv
// fsm_harness_pkg: shared sequencer state encoding, config select codes and default widths.
package fsm_harness_pkg;
    localparam int SW_DEF = 2;
    localparam int IW_DEF = 2;
    localparam int OW_DEF = 4;
    localparam logic CFG_TRANS = 1'b0;
    localparam logic CFG_OUT = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RUN, S_DONE, S_ERR} seq_state_t;
endpackage

// File: rtl/moore_table_mem.sv
// moore_table_mem: transition/output tables with per-entry valid bits and async read.
module moore_table_mem
    import fsm_harness_pkg::*;
#(
    parameter int SW = SW_DEF,
    parameter int IW = IW_DEF,
    parameter int OW = OW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic          i_sel,
    input  logic [SW-1:0] i_state,
    input  logic [IW-1:0] i_in,
    input  logic [OW-1:0] i_data,
    input  logic [SW-1:0] i_rd_state,
    input  logic [IW-1:0] i_rd_in,
    output logic [SW-1:0] o_ns,
    output logic [OW-1:0] o_out,
    output logic          o_all_valid
);
    localparam int NS = 2 ** SW;
    localparam int NI = 2 ** IW;
    logic [SW-1:0] r_trans [NS][NI];
    logic [OW-1:0] r_out [NS];
    logic [NS*NI-1:0] r_tvalid;
    logic [NS-1:0] r_ovalid;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tvalid <= '0;
            r_ovalid <= '0;
        end else if (i_we) begin
            if (i_sel == CFG_OUT) r_ovalid[i_state] <= 1'b1;
            else r_tvalid[{i_state, i_in}] <= 1'b1;
        end
    end
    // Table contents carry no reset; only the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (i_we) begin
            if (i_sel == CFG_OUT) r_out[i_state] <= i_data;
            else r_trans[i_state][i_in] <= i_data[SW-1:0];
        end
    end
    assign o_ns = r_trans[i_rd_state][i_rd_in];
    assign o_out = r_out[i_rd_state];
    assign o_all_valid = &r_tvalid && &r_ovalid;
endmodule

// File: rtl/moore_table_sequencer.sv
// moore_table_sequencer: steps a stimulus stream through a programmable Moore table,
// driving registered in/cs/ns/exp_out to the FSM under test.
module moore_table_sequencer
    import fsm_harness_pkg::*;
#(
    parameter int SW = SW_DEF,
    parameter int IW = IW_DEF,
    parameter int OW = OW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic          cfg_sel,
    input  logic [SW-1:0] cfg_state,
    input  logic [IW-1:0] cfg_in,
    input  logic [OW-1:0] cfg_data,
    output logic          cfg_rej,
    input  logic          start,
    input  logic          stop,
    input  logic          in_valid,
    input  logic [IW-1:0] in_data,
    output logic          in_ready,
    output logic [IW-1:0] fsm_in,
    output logic [SW-1:0] fsm_cs,
    output logic [SW-1:0] fsm_ns,
    output logic [OW-1:0] fsm_exp_out,
    output logic          step_valid,
    output logic          busy,
    output logic          tbl_err,
    output logic [15:0]   step_count
);
    seq_state_t r_state;
    logic [SW-1:0] r_cs_cur;
    logic [IW-1:0] r_fsm_in;
    logic [SW-1:0] r_fsm_cs, r_fsm_ns;
    logic [OW-1:0] r_fsm_exp_out;
    logic r_cfg_rej, r_step_valid, r_tbl_err;
    logic [15:0] r_step_count;
    logic w_busy, w_run, w_accept, w_all_valid;
    logic [SW-1:0] w_ns;
    logic [OW-1:0] w_out;
    assign w_run = r_state == S_RUN;
    assign w_busy = r_state == S_CHECK || w_run;
    assign w_accept = in_valid && w_run;
    moore_table_mem #(.SW(SW), .IW(IW), .OW(OW)) u_mem (
        .clk         (clk),
        .reset       (reset),
        .i_we        (cfg_we && !w_busy),
        .i_sel       (cfg_sel),
        .i_state     (cfg_state),
        .i_in        (cfg_in),
        .i_data      (cfg_data),
        .i_rd_state  (r_cs_cur),
        .i_rd_in     (in_data),
        .o_ns        (w_ns),
        .o_out       (w_out),
        .o_all_valid (w_all_valid)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cs_cur <= '0;
            r_fsm_in <= '0;
            r_fsm_cs <= '0;
            r_fsm_ns <= '0;
            r_fsm_exp_out <= '0;
            r_cfg_rej <= 1'b0;
            r_step_valid <= 1'b0;
            r_tbl_err <= 1'b0;
            r_step_count <= '0;
        end else begin
            r_cfg_rej <= cfg_we && w_busy;
            r_step_valid <= w_accept;
            if (w_accept) begin
                r_fsm_in <= in_data;
                r_fsm_cs <= r_cs_cur;
                r_fsm_ns <= w_ns;
                r_fsm_exp_out <= w_out;
                r_cs_cur <= w_ns;
                if (r_step_count != 16'hFFFF) r_step_count <= r_step_count + 16'd1;
            end
            case (r_state)
                S_IDLE, S_DONE, S_ERR: if (start) r_state <= S_CHECK;
                S_CHECK: begin
                    r_state <= w_all_valid ? S_RUN : S_ERR;
                    r_tbl_err <= !w_all_valid;
                    if (w_all_valid) begin
                        r_cs_cur <= '0;
                        r_step_count <= '0;
                    end
                end
                S_RUN: if (stop) r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign cfg_rej = r_cfg_rej;
    assign in_ready = w_run;
    assign busy = w_busy;
    assign fsm_in = r_fsm_in;
    assign fsm_cs = r_fsm_cs;
    assign fsm_ns = r_fsm_ns;
    assign fsm_exp_out = r_fsm_exp_out;
    assign step_valid = r_step_valid;
    assign tbl_err = r_tbl_err;
    assign step_count = r_step_count;
endmodule
